// File: rtl/mack_bus_timer.sv
// mack_bus_timer
//
// Bus-cycle timing stage for the Mackerel 68000 board. Sits upstream of the
// address decoder: watches AS and the decoder's ROM/RAM selects, inserts a
// per-region number of wait states before driving MEM_DTACK, and runs a
// bus-error watchdog that pulls BERR low when a cycle is never terminated.
//
// Parameters:
//   ROM_WAIT      wait states for ROM cycles
//   RAM_WAIT      wait states for RAM cycles
//   BERR_TIMEOUT  clocks of AS low without DTACK/VPA before BERR asserts;
//                 must exceed max(ROM_WAIT, RAM_WAIT) + 2
//   CNT_W         width of the wait and watchdog counters
//
// Ports (all active-low except CLK):
//   CLK        in   CPU clock
//   RST        in   synchronous reset
//   AS         in   CPU address strobe
//   ROMEN      in   ROM select from the decoder
//   RAMEN      in   RAM select from the decoder
//   BUS_DTACK  in   DTACK as seen by the CPU
//   VPA        in   valid peripheral address (autovector)
//   MEM_DTACK  out  wait-stated DTACK to the decoder's DTACK_IN
//   BERR       out  bus error to the CPU

module mack_bus_timer #(
    parameter int ROM_WAIT     = 2,
    parameter int RAM_WAIT     = 0,
    parameter int BERR_TIMEOUT = 64,
    parameter int CNT_W        = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic AS,
    input  logic ROMEN,
    input  logic RAMEN,
    input  logic BUS_DTACK,
    input  logic VPA,
    output logic MEM_DTACK,
    output logic BERR
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_BERR,
        ST_HOLD
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ROM_LOAD = CNT_W'(ROM_WAIT);
    localparam logic [CNT_W-1:0] RAM_LOAD = CNT_W'(RAM_WAIT);
    localparam logic [CNT_W-1:0] WD_MAX   = {CNT_W{1'b1}};
    // Value the watchdog holds one edge before it reaches the timeout.
    localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(BERR_TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic [CNT_W-1:0] wd_cnt, wd_cnt_nxt;
    logic             term, term_nxt;
    logic             wd_inc;
    logic             ack;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            wd_cnt   <= '0;
            term     <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            wd_cnt   <= wd_cnt_nxt;
            term     <= term_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        wd_cnt_nxt   = wd_cnt;
        term_nxt     = term;
        wd_inc       = 1'b0;

        case (state)
            ST_IDLE: begin
                wait_cnt_nxt = '0;
                wd_cnt_nxt   = '0;
                term_nxt     = 1'b0;
                if (!AS) begin
                    // Select is latched here; ROM wins when both are low.
                    if (!ROMEN) begin
                        wait_cnt_nxt = ROM_LOAD;
                        state_nxt    = (ROM_WAIT == 0) ? ST_ACK : ST_WAIT;
                    end else if (!RAMEN) begin
                        wait_cnt_nxt = RAM_LOAD;
                        state_nxt    = (RAM_WAIT == 0) ? ST_ACK : ST_WAIT;
                    end else begin
                        state_nxt    = ST_HOLD;
                    end
                end
            end

            default: begin
                if (AS) begin
                    state_nxt = ST_IDLE;
                end else begin
                    // Once DTACK or VPA has been seen, the watchdog freezes
                    // for the rest of the cycle even if they go high again.
                    wd_inc = BUS_DTACK && VPA && !term;
                    if (!BUS_DTACK || !VPA) begin
                        term_nxt = 1'b1;
                    end
                    if (wd_inc && (wd_cnt != WD_MAX)) begin
                        wd_cnt_nxt = wd_cnt + CNT_ONE;
                    end

                    if (wd_inc && (wd_cnt == WD_LAST)) begin
                        state_nxt = ST_BERR;
                    end else if (state == ST_WAIT) begin
                        wait_cnt_nxt = wait_cnt - CNT_ONE;
                        if (wait_cnt == CNT_ONE) begin
                            state_nxt = ST_ACK;
                        end
                    end
                end
            end
        endcase
    end

    assign ack = (state == ST_ACK);

    // DTACK negation tracks AS combinationally so the CPU sees it release
    // in the same delta as the strobe.
    assign MEM_DTACK = ~(ack & ~AS);
    assign BERR      = (state != ST_BERR);

endmodule

// File: tb/tb_mack_bus_timer.sv
module tb_mack_bus_timer;

    localparam int ROM_WAIT     = 2;
    localparam int RAM_WAIT     = 0;
    localparam int BERR_TIMEOUT = 64;
    localparam int CNT_W        = 8;

    logic CLK       = 1'b0;
    logic RST       = 1'b0;
    logic AS        = 1'b1;
    logic ROMEN     = 1'b1;
    logic RAMEN     = 1'b1;
    logic BUS_DTACK = 1'b1;
    logic VPA       = 1'b1;
    logic MEM_DTACK;
    logic BERR;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mack_bus_timer #(
        .ROM_WAIT    (ROM_WAIT),
        .RAM_WAIT    (RAM_WAIT),
        .BERR_TIMEOUT(BERR_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .AS       (AS),
        .ROMEN    (ROMEN),
        .RAMEN    (RAMEN),
        .BUS_DTACK(BUS_DTACK),
        .VPA      (VPA),
        .MEM_DTACK(MEM_DTACK),
        .BERR     (BERR)
    );

    // Reference model: a bus cycle is described by its age in edges, the
    // wait count chosen at its start, and the number of unterminated clocks
    // seen so far. Acknowledge is "age >= wait count", bus error is
    // "unterminated clocks >= timeout".
    bit m_in   = 1'b0;
    int m_age  = 0;
    int m_wn   = -1;
    bit m_term = 1'b0;
    int m_wd   = 0;
    bit m_berr = 1'b0;
    bit m_ack  = 1'b0;

    function automatic int wd_after();
        return m_wd + ((BUS_DTACK && VPA && !m_term) ? 1 : 0);
    endfunction

    always @(posedge CLK) begin
        if (!RST) begin
            m_in   <= 1'b0;
            m_ack  <= 1'b0;
            m_berr <= 1'b0;
        end else if (!m_in) begin
            if (!AS) begin
                m_in   <= 1'b1;
                m_age  <= 0;
                m_term <= 1'b0;
                m_wd   <= 0;
                m_berr <= 1'b0;
                if (!ROMEN) begin
                    m_wn  <= ROM_WAIT;
                    m_ack <= (ROM_WAIT == 0);
                end else if (!RAMEN) begin
                    m_wn  <= RAM_WAIT;
                    m_ack <= (RAM_WAIT == 0);
                end else begin
                    m_wn  <= -1;
                    m_ack <= 1'b0;
                end
            end
        end else if (AS) begin
            m_in   <= 1'b0;
            m_ack  <= 1'b0;
            m_berr <= 1'b0;
        end else begin
            m_age  <= m_age + 1;
            m_wd   <= wd_after();
            m_term <= m_term || !BUS_DTACK || !VPA;
            m_berr <= m_berr || (wd_after() >= BERR_TIMEOUT);
            m_ack  <= !(m_berr || (wd_after() >= BERR_TIMEOUT)) &&
                      (m_wn >= 0) && (m_age + 1 >= m_wn);
        end
    end

    function automatic logic exp_mem();
        return !(m_ack && !AS);
    endfunction

    function automatic logic exp_berr();
        return !m_berr;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic as_v, input logic rom_v, input logic ram_v);
        AS    = as_v;
        ROMEN = rom_v;
        RAMEN = ram_v;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        drive(1'b1, 1'b1, 1'b1);
        tick();
        tick();
        checks++;
        if (MEM_DTACK !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle_mem: got %b want 1", MEM_DTACK);
        end
        checks++;
        if (BERR !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle_berr: got %b want 1", BERR);
        end
        // Start a ROM cycle and let it acknowledge.
        RST = 1'b1;
        drive(1'b0, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        checks++;
        if (MEM_DTACK !== 1'b0) begin
            errors++;
            $display("FAIL reset_pre_ack: got %b want 0", MEM_DTACK);
        end
        // Reset in the middle of the acknowledged cycle, AS still low.
        RST = 1'b0;
        tick();
        checks++;
        if (MEM_DTACK !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_mem: got %b want 1", MEM_DTACK);
        end
        checks++;
        if (BERR !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_berr: got %b want 1", BERR);
        end
        drive(1'b1, 1'b1, 1'b1);
        tick();
        RST = 1'b1;
        tick();
        // From idle, a RAM-only cycle acknowledges right after its start edge.
        drive(1'b0, 1'b1, 1'b0);
        tick();
        checks++;
        if (MEM_DTACK !== 1'b0) begin
            errors++;
            $display("FAIL reset_then_ram: got %b want 0", MEM_DTACK);
        end
        drive(1'b1, 1'b1, 1'b1);
        tick();
    endtask

    task automatic test_rom_read();
        logic want;
        drive(1'b0, 1'b0, 1'b1);
        tick();
        for (int e = 0; e <= 4; e++) begin
            if (e > 0) tick();
            want = (e >= 2) ? 1'b0 : 1'b1;
            checks++;
            if (MEM_DTACK !== want) begin
                errors++;
                $display("FAIL rom_latency k+%0d: got %b want %b", e, MEM_DTACK, want);
            end
            checks++;
            if (BERR !== 1'b1) begin
                errors++;
                $display("FAIL rom_berr k+%0d: got %b want 1", e, BERR);
            end
        end
        #2;
        drive(1'b1, 1'b1, 1'b1);
        #0;
        checks++;
        if (MEM_DTACK !== 1'b1) begin
            errors++;
            $display("FAIL rom_as_rise_comb: got %b want 1", MEM_DTACK);
        end
        tick();
        checks++;
        if (MEM_DTACK !== 1'b1 || BERR !== 1'b1) begin
            errors++;
            $display("FAIL rom_after_rise: got mem=%b berr=%b want 1 1", MEM_DTACK, BERR);
        end
    endtask

    task automatic test_ram_read();
        logic want;
        // Both selects low: ROM timing applies.
        drive(1'b0, 1'b0, 1'b0);
        tick();
        for (int e = 0; e <= 3; e++) begin
            if (e > 0) tick();
            want = (e >= ROM_WAIT) ? 1'b0 : 1'b1;
            checks++;
            if (MEM_DTACK !== want) begin
                errors++;
                $display("FAIL overlap_latency k+%0d: got %b want %b", e, MEM_DTACK, want);
            end
        end
        drive(1'b1, 1'b1, 1'b1);
        tick();
        // RAM only: zero wait states.
        drive(1'b0, 1'b1, 1'b0);
        tick();
        for (int e = 0; e <= 2; e++) begin
            if (e > 0) tick();
            checks++;
            if (MEM_DTACK !== 1'b0) begin
                errors++;
                $display("FAIL ram_latency k+%0d: got %b want 0", e, MEM_DTACK);
            end
        end
        drive(1'b1, 1'b1, 1'b1);
        tick();
    endtask

    task automatic test_berr_timeout();
        logic want;
        drive(1'b0, 1'b1, 1'b1);
        tick();
        for (int e = 0; e <= BERR_TIMEOUT + 6; e++) begin
            if (e > 0) tick();
            want = (e >= BERR_TIMEOUT) ? 1'b0 : 1'b1;
            checks++;
            if (BERR !== want) begin
                errors++;
                $display("FAIL berr_timeout k+%0d: got %b want %b", e, BERR, want);
            end
            checks++;
            if (MEM_DTACK !== 1'b1) begin
                errors++;
                $display("FAIL berr_unsel_mem k+%0d: got %b want 1", e, MEM_DTACK);
            end
        end
        #2;
        AS = 1'b1;
        #1;
        checks++;
        if (BERR !== 1'b0) begin
            errors++;
            $display("FAIL berr_hold_till_edge: got %b want 0", BERR);
        end
        tick();
        checks++;
        if (BERR !== 1'b1) begin
            errors++;
            $display("FAIL berr_clear: got %b want 1", BERR);
        end
    endtask

    task automatic test_termination();
        // VPA pulse at k+10 freezes the watchdog for the rest of the cycle.
        drive(1'b0, 1'b1, 1'b1);
        tick();
        for (int e = 1; e <= 200; e++) begin
            VPA = (e == 10) ? 1'b0 : 1'b1;
            tick();
            checks++;
            if (BERR !== 1'b1) begin
                errors++;
                $display("FAIL vpa_term k+%0d: got %b want 1", e, BERR);
            end
        end
        VPA = 1'b1;
        drive(1'b1, 1'b1, 1'b1);
        tick();
        // DTACK on exactly the edge the count would reach the timeout.
        drive(1'b0, 1'b1, 1'b1);
        tick();
        for (int e = 1; e <= 100; e++) begin
            BUS_DTACK = (e == BERR_TIMEOUT) ? 1'b0 : 1'b1;
            tick();
            checks++;
            if (BERR !== 1'b1) begin
                errors++;
                $display("FAIL dtack_race k+%0d: got %b want 1", e, BERR);
            end
        end
        BUS_DTACK = 1'b1;
        drive(1'b1, 1'b1, 1'b1);
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        int hold;
        int first;
        bit rom;
        for (int c = 0; c < 20; c++) begin
            rom  = (c % 2 == 0);
            n    = rom ? ROM_WAIT : RAM_WAIT;
            hold = int'($urandom_range(1, 4));
            drive(1'b0, !rom, rom);
            tick();
            first = -1;
            for (int e = 0; e <= n + hold; e++) begin
                if (e > 0) tick();
                if (first < 0 && MEM_DTACK === 1'b0) first = e;
                checks++;
                if (BERR !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_berr cyc=%0d k+%0d: got %b want 1", c, e, BERR);
                end
                checks++;
                if (MEM_DTACK !== exp_mem()) begin
                    errors++;
                    $display("FAIL b2b_model cyc=%0d k+%0d: got %b want %b", c, e, MEM_DTACK, exp_mem());
                end
                // Select wiggles after the start edge must be ignored.
                ROMEN = 1'($urandom_range(0, 1));
                RAMEN = 1'($urandom_range(0, 1));
            end
            checks++;
            if (first !== n) begin
                errors++;
                $display("FAIL b2b_latency cyc=%0d: got k+%0d want k+%0d", c, first, n);
            end
            drive(1'b1, 1'b1, 1'b1);
            tick();
            checks++;
            if (MEM_DTACK !== 1'b1) begin
                errors++;
                $display("FAIL b2b_gap cyc=%0d: got %b want 1", c, MEM_DTACK);
            end
        end
    endtask

    task automatic test_random();
        int len;
        int gap;
        for (int c = 0; c < 40; c++) begin
            len   = int'($urandom_range(1, 90));
            gap   = int'($urandom_range(1, 3));
            ROMEN = 1'($urandom_range(0, 1));
            RAMEN = 1'($urandom_range(0, 1));
            AS    = 1'b0;
            for (int e = 0; e < len; e++) begin
                BUS_DTACK = ($urandom_range(0, 29) == 0) ? 1'b0 : 1'b1;
                VPA       = ($urandom_range(0, 29) == 0) ? 1'b0 : 1'b1;
                tick();
                checks++;
                if (MEM_DTACK !== exp_mem()) begin
                    errors++;
                    $display("FAIL rand_mem cyc=%0d e=%0d: got %b want %b", c, e, MEM_DTACK, exp_mem());
                end
                checks++;
                if (BERR !== exp_berr()) begin
                    errors++;
                    $display("FAIL rand_berr cyc=%0d e=%0d: got %b want %b", c, e, BERR, exp_berr());
                end
                ROMEN = 1'($urandom_range(0, 1));
                RAMEN = 1'($urandom_range(0, 1));
            end
            BUS_DTACK = 1'b1;
            VPA       = 1'b1;
            #2;
            drive(1'b1, 1'b1, 1'b1);
            #1;
            checks++;
            if (MEM_DTACK !== exp_mem()) begin
                errors++;
                $display("FAIL rand_as_rise cyc=%0d: got %b want %b", c, MEM_DTACK, exp_mem());
            end
            for (int g = 0; g < gap; g++) begin
                tick();
                checks++;
                if (MEM_DTACK !== exp_mem() || BERR !== exp_berr()) begin
                    errors++;
                    $display("FAIL rand_gap cyc=%0d: got mem=%b berr=%b want %b %b",
                             c, MEM_DTACK, BERR, exp_mem(), exp_berr());
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_rom_read();
        test_ram_read();
        test_berr_timeout();
        test_termination();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
